frame_threshold_display: RTL and testbench

Output-side counterpart of the key-driven threshold adjuster: takes the current frame grade (4 bit) and frame threshold (8 bit) and shows them on a 4-digit multiplexed seven-segment display. Digit 3 shows the grade in hex with its decimal point lit as a separator. Digits 2..0 show the threshold in decimal (000–255), produced by a sequential binary-to-BCD converter. The block sits beside the threshold adjuster in the top level and drives the board display pins directly.

---
 rtl/frame_disp_pkg.sv | 31 +++
 rtl/bin2bcd_seq.sv | 53 +++++
 rtl/frame_threshold_display.sv | 81 ++++++++
 tb/tb_frame_threshold_display.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/frame_disp_pkg.sv
// frame_disp_pkg: shared converter states, digit indices and glyph encoder for the frame display
package frame_disp_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LOAD} conv_state_t;
    localparam logic [7:0] SEG_OFF = 8'h00;
    localparam logic [1:0] DIG_UNITS = 2'd0;
    localparam logic [1:0] DIG_TENS = 2'd1;
    localparam logic [1:0] DIG_HUND = 2'd2;
    localparam logic [1:0] DIG_GRADE = 2'd3;
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: 8-bit sequential double-dabble converter, one bit per cycle
module bin2bcd_seq
    import frame_disp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
    output logic       busy,
    output logic       done,
    output logic [9:0] bcd
);
    conv_state_t state, state_nxt;
    logic [7:0] bin;
    logic [2:0] cnt;
    logic [9:0] adj;
    // state register
    always_ff @(posedge clk) state <= rst ? ST_IDLE : state_nxt;
    // next state: start only honoured in IDLE, eight shifts then one load cycle
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = start ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: state_nxt = cnt == 3'd7 ? ST_LOAD : ST_SHIFT;
            default:  state_nxt = ST_IDLE;
        endcase
    end
    // status outputs
    always_comb begin
        busy = state != ST_IDLE;
        done = state == ST_LOAD;
    end
    // add-3 on tens and units; hundreds never exceeds 2 so it needs no correction
    always_comb begin
        adj = bcd;
        adj[3:0] = bcd[3:0] >= 4'd5 ? bcd[3:0] + 4'd3 : bcd[3:0];
        adj[7:4] = bcd[7:4] >= 4'd5 ? bcd[7:4] + 4'd3 : bcd[7:4];
    end
    // working shift register: load on start, shift MSB-first into the accumulator
    always_ff @(posedge clk)
        if (rst) begin
            bin <= '0;
            bcd <= '0;
            cnt <= '0;
        end else if (state == ST_IDLE && start) begin
            bin <= din;
            bcd <= '0;
            cnt <= '0;
        end else if (state == ST_SHIFT) begin
            {bcd, bin} <= {adj[8:0], bin, 1'b0};
            cnt <= cnt + 3'd1;
        end
endmodule

// File: rtl/frame_threshold_display.sv
// frame_threshold_display: shows grade (hex) and threshold (decimal) on a 4-digit muxed 7-seg display
module frame_threshold_display
    import frame_disp_pkg::*;
#(
    parameter int SCAN_DIV       = 100_000,
    parameter int GUARD          = 16,
    parameter int BLANK_LZ       = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Frame_Grade,
    input  logic [7:0] Frame_Threshold,
    output logic [7:0] seg,
    output logic [3:0] dig_sel,
    output logic       busy
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] SLOT_GUARD = CW'(GUARD);
    localparam logic [7:0] SEG_INV = SEG_ACTIVE_LOW != 0 ? 8'hFF : 8'h00;
    logic [11:0] shadow;
    logic [3:0] grade_w, disp_grade, nib, sel;
    logic [9:0] bcd, disp_bcd;
    logic start, done, blank, wrap;
    logic [CW-1:0] slot_cnt;
    logic [1:0] dig_idx;
    logic [7:0] glyph;
    assign start = {Frame_Grade, Frame_Threshold} != shadow;
    assign wrap = slot_cnt == SLOT_LAST;
    bin2bcd_seq u_conv (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .din  (Frame_Threshold),
        .busy (busy),
        .done (done),
        .bcd  (bcd)
    );
    // capture inputs when the converter accepts them, publish result on load
    always_ff @(posedge clk)
        if (rst) begin
            shadow <= '0;
            grade_w <= '0;
            disp_grade <= '0;
            disp_bcd <= '0;
        end else begin
            if (start && !busy) begin
                shadow <= {Frame_Grade, Frame_Threshold};
                grade_w <= Frame_Grade;
            end
            if (done) begin
                disp_bcd <= bcd;
                disp_grade <= grade_w;
            end
        end
    // slot counter and digit index
    always_ff @(posedge clk)
        if (rst) begin
            slot_cnt <= '0;
            dig_idx <= '0;
        end else begin
            slot_cnt <= wrap ? '0 : slot_cnt + 1'b1;
            dig_idx <= dig_idx + {1'b0, wrap};
        end
    // glyph select with guard interval and leading-zero blanking
    always_comb begin
        nib = dig_idx == DIG_GRADE ? disp_grade :
              dig_idx == DIG_HUND  ? {2'b00, disp_bcd[9:8]} :
              dig_idx == DIG_TENS  ? disp_bcd[7:4] : disp_bcd[3:0];
        blank = BLANK_LZ != 0 && disp_bcd[9:8] == 2'd0 &&
                (dig_idx == DIG_HUND || (dig_idx == DIG_TENS && disp_bcd[7:4] == 4'd0));
        glyph = (slot_cnt < SLOT_GUARD || blank) ? SEG_OFF : {dig_idx == DIG_GRADE, hex7(nib)};
        sel = slot_cnt < SLOT_GUARD ? 4'b0000 : 4'b0001 << dig_idx;
    end
    // output registers; polarity applied only here
    always_ff @(posedge clk) begin
        seg <= SEG_INV ^ (rst ? SEG_OFF : glyph);
        dig_sel <= SEG_INV[3:0] ^ (rst ? 4'b0000 : sel);
    end
endmodule

// File: tb/tb_frame_threshold_display.sv
// tb_frame_threshold_display: scoreboard bench for conversion, blanking, reset and scan timing
module tb_frame_threshold_display;
    localparam int SD = 40, GD = 4;
    typedef struct {
        logic [3:0] g;
        logic [7:0] t;
    } item_t;
    logic clk = 1'b0, rst = 1'b1;
    logic [3:0] grade = 4'h0;
    logic [7:0] thr = 8'h00;
    logic [7:0] seg, seg0;
    logic [3:0] dig_sel, dig_sel0;
    logic busy, busy0;
    item_t sb[$];
    int checks = 0, failures = 0;
    logic [7:0] hex_al [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    frame_threshold_display #(.SCAN_DIV(SD), .GUARD(GD), .BLANK_LZ(1), .SEG_ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .Frame_Grade(grade), .Frame_Threshold(thr),
        .seg(seg), .dig_sel(dig_sel), .busy(busy)
    );
    frame_threshold_display #(.SCAN_DIV(SD), .GUARD(GD), .BLANK_LZ(0), .SEG_ACTIVE_LOW(1)) dut0 (
        .clk(clk), .rst(rst), .Frame_Grade(grade), .Frame_Threshold(thr),
        .seg(seg0), .dig_sel(dig_sel0), .busy(busy0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL %s obs=%0h want=%0h", tag, obs, want);
        end
    endtask

    function automatic item_t mk(input logic [3:0] g, input logic [7:0] t);
        item_t e;
        e.g = g;
        e.t = t;
        return e;
    endfunction

    function automatic logic [9:0] bcd_of(input logic [7:0] t);
        int v = int'(t);
        return {2'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] glyph_of(input int d, input item_t e, input bit blz);
        int v = int'(e.t);
        int h = v / 100;
        int te = (v / 10) % 10;
        int u = v % 10;
        if (d == 3) return hex_al[e.g] & 8'h7F;
        if (d == 2) return (blz && h == 0) ? 8'hFF : hex_al[h];
        if (d == 1) return (blz && h == 0 && te == 0) ? 8'hFF : hex_al[te];
        return hex_al[u];
    endfunction

    task automatic apply(input item_t e);
        grade = e.g;
        thr = e.t;
        sb.push_back(e);
    endtask

    task automatic sb_pop_check();
        item_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check("disp_bcd", 32'(dut.disp_bcd), 32'(bcd_of(e.t)));
        check("disp_grade", 32'(dut.disp_grade), 32'(e.g));
    endtask

    task automatic trace(input int n, input int chg, input item_t nx, output logic [31:0] tr);
        tr = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tr[i] = busy;
            if (i > 0 && tr[i-1] && !busy) sb_pop_check();
            if (i == chg) apply(nx);
        end
    endtask

    task automatic check_display(input item_t e);
        for (int d = 0; d < 4; d++) begin
            int n = 0;
            logic [3:0] tgt = ~(4'b0001 << d);
            do begin
                @(negedge clk);
                n++;
            end while (dig_sel !== tgt && n < 4 * SD + 10);
            check($sformatf("sel%0d", d), 32'(dig_sel), 32'(tgt));
            check($sformatf("seg%0d", d), 32'(seg), 32'(glyph_of(d, e, 1'b1)));
            check($sformatf("seg%0d_nb", d), 32'(seg0), 32'(glyph_of(d, e, 1'b0)));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog obs=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        item_t e, e2;
        logic [31:0] tr;
        logic [3:0] s [480];
        logic [3:0] d, prev;
        int p, run, multi;
        prev = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_sel", 32'(dig_sel), 32'hF);
        check("rst_seg", 32'(seg), 32'hFF);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("lit_sel", 32'(dig_sel), 32'hE);
        check("zero_idle", 32'(busy), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_sel", 32'(dig_sel), 32'hF);
        check("mid_rst_seg", 32'(seg), 32'hFF);
        rst = 1'b0;
        check_display(mk(4'h0, 8'd0));

        e = mk(4'hF, 8'd255);
        apply(e);
        trace(12, -1, e, tr);
        check("busy_255", tr, 32'h1FF);
        check_display(e);

        e = mk(4'h0, 8'd7);
        apply(e);
        trace(12, -1, e, tr);
        check("busy_7", tr, 32'h1FF);
        check_display(e);

        e = mk(4'h3, 8'd100);
        e2 = mk(4'h3, 8'd101);
        apply(e);
        trace(24, 2, e2, tr);
        check("busy_twice", tr, 32'h7FDFF);
        check_display(e2);

        e = mk(4'h5, 8'd200);
        grade = e.g;
        thr = e.t;
        repeat (4) @(negedge clk);
        check("abort_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bcd", 32'(dut.disp_bcd), 32'd0);
        check("abort_grade", 32'(dut.disp_grade), 32'd0);
        check("abort_sel", 32'(dig_sel), 32'hF);
        rst = 1'b0;
        sb.push_back(e);
        trace(12, -1, e, tr);
        check("busy_200", tr, 32'h1FF);
        check_display(e);
        check("sb_drained", 32'(sb.size()), 32'd0);

        for (int i = 0; i < 480; i++) begin
            @(negedge clk);
            s[i] = ~dig_sel;
        end
        multi = 0;
        for (int i = 0; i < 480; i++) if ($countones(s[i]) > 1) multi++;
        check("onehot", 32'(multi), 32'd0);
        p = 0;
        while (p < 480 && s[p] != 4'h0) p++;
        while (p < 480 && s[p] == 4'h0) p++;
        for (int k = 0; k < 8; k++) begin
            d = (p < 480) ? s[p] : 4'h0;
            run = 0;
            while (p < 480 && s[p] == d) begin
                run++;
                p++;
            end
            check($sformatf("lit_len%0d", k), 32'(run), 32'd36);
            if (k > 0) check($sformatf("order%0d", k), 32'(d), 32'({prev[2:0], prev[3]}));
            prev = d;
            run = 0;
            while (p < 480 && s[p] == 4'h0) begin
                run++;
                p++;
            end
            check($sformatf("off_len%0d", k), 32'(run), 32'd4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
